// File: rtl/cpu_ctrl_fsm_pkg.sv
// ctrl_pkg: shared types and constants for the cpu_ctrl_fsm controller.
// State encoding, opcode/op field values, writeback mux selects, ALU op
// codes and a small instruction-class helper used by the decoder.
package ctrl_pkg;

  // Controller states; value 3'd7 is unused and recovers to WAIT.
  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    DECODE = 3'd1,
    WR_IMM = 3'd2,
    GET_A  = 3'd3,
    GET_B  = 3'd4,
    EXEC   = 3'd5,
    WR_REG = 3'd6
  } state_t;

  // Opcode (IR[15:13]) and op (IR[12:11]) values
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_CMP     = 2'b01;

  // Writeback mux selects
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // ALU operation codes
  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] AND  = 2'b10;
  localparam logic [1:0] NOTB = 2'b11;

  // Instruction classes: each class follows one fixed state path
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_MVN     = 3'd3,
    CLS_ALU     = 3'd4,
    CLS_CMP     = 3'd5
  } instr_cls_t;

  // Map opcode/op to an instruction class; anything unlisted is illegal.
  function automatic instr_cls_t classify(input logic [2:0] opc, input logic [1:0] op);
    instr_cls_t c;
    c = CLS_ILLEGAL;
    case (opc)
      OPC_MOV: begin
        case (op)
          OP_MOV_IMM: c = CLS_MOV_IMM;
          OP_MOV_REG: c = CLS_MOV_REG;
          default:    c = CLS_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (op)
          OP_MVN:  c = CLS_MVN;
          OP_CMP:  c = CLS_CMP;
          default: c = CLS_ALU;
        endcase
      end
      default: c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_if: start/ready handshake, instruction/status inputs and the
// datapath control bundle of cpu_ctrl_fsm. master = controller side,
// slave = datapath / stimulus side.
interface cpu_ctrl_if #(parameter int W = 16);
  logic          s;
  logic          load;
  logic [15:0]   in;
  logic [2:0]    stat;
  logic          w;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic          write;
  logic [1:0]    vsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;
  logic [1:0]    alu_op;
  logic [1:0]    shift;
  logic [W-1:0]  sximm8;
  logic [2:0]    flags;
  logic          err;

  modport master (
    input  s, load, in, stat,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, alu_op, shift, sximm8, flags, err
  );

  modport slave (
    output s, load, in, stat,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, alu_op, shift, sximm8, flags, err
  );
endinterface

// File: rtl/cpu_ctrl_fsm_instr_decode.sv
// instr_decode: purely combinational field extraction for the latched
// instruction, sign extension of the 8-bit immediate and classification.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 8
) (
  input  logic [15:0]  ir,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [1:0]   sh,
  output logic [2:0]   rm,
  output logic [W-1:0] sximm8,
  output instr_cls_t   cls,
  output logic         legal
);
  logic [2:0] opc;

  assign opc    = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign cls    = classify(opc, op);
  assign legal  = (cls != CLS_ILLEGAL);
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle controller for the 16-bit ALU/register datapath.
// Latches one instruction in WAIT, then walks a fixed state path per
// instruction class. All datapath controls are Moore outputs of state + IR,
// so an asynchronous reset drops them immediately.
// Optional feature macro: ALU_FLAGS_REG_EN (captures {V,N,Z} on loads).
module cpu_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 8
) (
  input logic        clk,
  input logic        reset,
  cpu_ctrl_if.master bus
);
  state_t      state;
  state_t      next_state;
  logic [15:0] ir;

  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;
  logic [W-1:0] sximm8;
  instr_cls_t  cls;
  logic        legal;
  logic        loads_s;

  instr_decode #(.W(W), .IMM_W(IMM_W)) u_decode (
    .ir     (ir),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .cls    (cls),
    .legal  (legal)
  );

  assign bus.sximm8 = sximm8;
  assign bus.loads  = loads_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register: only loaded while idle, so load during a run is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= 16'h0000;
    end else if (state == WAIT && bus.load) begin
      ir <= bus.in;
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    next_state   = WAIT;
    bus.w        = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.vsel     = VSEL_C;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    loads_s      = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.alu_op   = ADD;
    bus.shift    = 2'b00;
    bus.err      = 1'b0;
    case (state)
      WAIT: begin
        bus.w = 1'b1;
        if (bus.s) begin
          next_state = DECODE;
        end else begin
          next_state = WAIT;
        end
      end
      DECODE: begin
        case (cls)
          CLS_MOV_IMM:          next_state = WR_IMM;
          CLS_MOV_REG, CLS_MVN: next_state = GET_B;
          CLS_ALU, CLS_CMP:     next_state = GET_A;
          default: begin
            next_state = WAIT;
            bus.err    = ~legal;
          end
        endcase
      end
      WR_IMM: begin
        bus.writenum = rn;
        bus.vsel     = VSEL_IMM;
        bus.write    = 1'b1;
        next_state   = WAIT;
      end
      GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        next_state  = GET_B;
      end
      GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        bus.shift   = sh;
        next_state  = EXEC;
      end
      EXEC: begin
        bus.shift = sh;
        // MOV reg passes B through an add with A forced to zero
        if (cls == CLS_MOV_REG) begin
          bus.asel   = 1'b1;
          bus.alu_op = ADD;
        end else begin
          bus.asel   = 1'b0;
          bus.alu_op = op;
        end
        // Compare only updates status; everything else goes to C and writeback
        if (cls == CLS_CMP) begin
          loads_s    = 1'b1;
          next_state = WAIT;
        end else begin
          bus.loadc  = 1'b1;
          next_state = WR_REG;
        end
      end
      WR_REG: begin
        bus.writenum = rd;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
        next_state   = WAIT;
      end
      default: next_state = WAIT;
    endcase
  end

`ifdef ALU_FLAGS_REG_EN
  logic [2:0] flags_r;

  // Flag register: capture {V,N,Z} whenever the status register loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 3'b000;
    end else if (loads_s) begin
      flags_r <= {bus.stat[2], bus.stat[1], bus.stat[0]};
    end
  end

  assign bus.flags = flags_r;
`else
  assign bus.flags = 3'b000;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: randomized scoreboard bench for cpu_ctrl_fsm.
// The driver pushes, per instruction, the list of control vectors expected
// on each busy cycle (derived from the instruction class rules); a monitor
// pops one entry per busy cycle and compares.
module tb_cpu_ctrl_fsm;
  logic clk = 1'b0;
  logic reset;

  cpu_ctrl_if #(.W(16)) bus ();

  cpu_ctrl_fsm #(.W(16), .IMM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] alu_op;
    logic [1:0] shift;
    logic       err;
  } ctl_t;

  ctl_t        exp_q[$];
  ctl_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [2:0]  model_flags = 3'b000;
  logic [15:0] model_ir    = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t v;
    v.readnum  = bus.readnum;
    v.writenum = bus.writenum;
    v.write    = bus.write;
    v.vsel     = bus.vsel;
    v.loada    = bus.loada;
    v.loadb    = bus.loadb;
    v.loadc    = bus.loadc;
    v.loads    = bus.loads;
    v.asel     = bus.asel;
    v.bsel     = bus.bsel;
    v.alu_op   = bus.alu_op;
    v.shift    = bus.shift;
    v.err      = bus.err;
    return v;
  endfunction

  function automatic logic [15:0] sext8(input logic [15:0] x);
    return {{8{x[7]}}, x[7:0]};
  endfunction

  // Reference model: per-cycle control vectors for one instruction
  task automatic push_expect(input logic [15:0] ir, output int lat, output bit is_cmp);
    logic [2:0] opc;
    logic [1:0] op;
    ctl_t v;
    opc = ir[15:13];
    op  = ir[12:11];
    is_cmp = (opc == 3'b101) && (op == 2'b01);
    lat = 0;
    v = '0;
    if (!((opc == 3'b110 && (op == 2'b10 || op == 2'b00)) || opc == 3'b101)) begin
      v.err = 1'b1;
      exp_q.push_back(v); lat = 1;
      return;
    end
    exp_q.push_back(v); lat = 1;
    if (opc == 3'b110 && op == 2'b10) begin
      v = '0; v.write = 1'b1; v.writenum = ir[10:8]; v.vsel = 2'b10;
      exp_q.push_back(v); lat++;
      return;
    end
    if (opc == 3'b101 && op != 2'b11) begin
      v = '0; v.loada = 1'b1; v.readnum = ir[10:8];
      exp_q.push_back(v); lat++;
    end
    v = '0; v.loadb = 1'b1; v.readnum = ir[2:0]; v.shift = ir[4:3];
    exp_q.push_back(v); lat++;
    v = '0; v.shift = ir[4:3];
    if (opc == 3'b110) begin
      v.asel = 1'b1; v.alu_op = 2'b00; v.loadc = 1'b1;
    end else begin
      v.alu_op = op;
      if (is_cmp) v.loads = 1'b1;
      else        v.loadc = 1'b1;
    end
    exp_q.push_back(v); lat++;
    if (!is_cmp) begin
      v = '0; v.write = 1'b1; v.writenum = ir[7:5]; v.vsel = 2'b00;
      exp_q.push_back(v); lat++;
    end
  endtask

  // Monitor: one expected vector per busy (w=0) cycle
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.w === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("busy_without_expect", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("ctl_vector", 32'(observed()), 32'(mon_e));
      end
    end
  end

  // mode 0: s only (reuse IR), 1: load then s, 2: load and s together
  task automatic run_instr(input logic [15:0] instr, input logic [2:0] stat_v, input int mode);
    int  lat;
    bit  is_cmp;
    int  n;
    bit  done;
    @(negedge clk);
    bus.stat = stat_v;
    if (mode == 0) begin
      bus.s = 1'b1; bus.load = 1'b0;
    end else begin
      bus.in = instr; bus.load = 1'b1; bus.s = (mode == 2);
      model_ir = instr;
      if (mode == 1) begin
        @(negedge clk);
        bus.load = 1'b0; bus.s = 1'b1; bus.in = 16'($urandom);
      end
    end
    push_expect(model_ir, lat, is_cmp);
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (n == 0) check("sximm8", bus.sximm8, sext8(model_ir));
      if (bus.w === 1'b1) begin
        done = 1'b1;
        bus.s = 1'b0; bus.load = 1'b0;
      end else if (n >= 30) begin
        done = 1'b1;
        bus.s = 1'b0; bus.load = 1'b0;
      end else begin
        n++;
        bus.s    = 1'($urandom_range(0, 1));
        bus.load = 1'($urandom_range(0, 1));
        bus.in   = 16'($urandom);
      end
    end
    check("latency", n, lat);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_outputs", 32'(observed()), 32'd0);
`ifdef ALU_FLAGS_REG_EN
    if (is_cmp) model_flags = stat_v;
`endif
    check("flags", bus.flags, model_flags);
  endtask

  initial begin
    logic [15:0] r;
    logic [2:0]  opc;
    int          sel;
    reset = 1'b1;
    bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000; bus.stat = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_w", bus.w, 1'b1);
    check("rst_ctl", 32'(observed()), 32'd0);
    check("rst_flags", bus.flags, 3'b000);
    check("rst_sximm8", bus.sximm8, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_w", bus.w, 1'b1);

    // Directed cases
    run_instr(16'hD205, 3'b000, 1);   // MOV R2,#5
    run_instr(16'hA043, 3'b010, 1);   // ADD R2,R0,R3
    run_instr(16'hA919, 3'b101, 2);   // CMP R1,R1 with stat V=1,Z=1
    run_instr(16'hE000, 3'b000, 1);   // illegal opcode
    run_instr(16'hD2FF, 3'b111, 2);   // MOV imm, sximm8 = FFFF
    run_instr(16'hC0E1, 3'b000, 1);   // MOV reg R7,R1
    run_instr(16'hB8AE, 3'b000, 1);   // MVN R5,R6 with shift
    run_instr(16'hB0A2, 3'b011, 2);   // AND R5,R0,R2
    run_instr(16'hA903, 3'b010, 1);   // CMP: flags follow new stat
    run_instr(16'hD000, 3'b000, 0);   // s only: reruns the held instruction

    // Asynchronous reset in GET_B of an ADD
    @(negedge clk);
    bus.in = 16'hA043; bus.load = 1'b1; bus.s = 1'b1;
    model_ir = 16'hA043;
    begin
      int lat; bit c;
      push_expect(model_ir, lat, c);
    end
    repeat (3) begin
      @(negedge clk);
      bus.s = 1'b0; bus.load = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("async_rst_w", bus.w, 1'b1);
    check("async_rst_loadb", bus.loadb, 1'b0);
    check("async_rst_ctl", 32'(observed()), 32'd0);
    check("async_rst_flags", bus.flags, 3'b000);
    exp_q.delete();
    model_ir = 16'h0000;
    model_flags = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    run_instr(16'h0000, 3'b000, 0);   // IR cleared by reset: illegal
    run_instr(16'hA043, 3'b000, 1);   // re-execute after reset

    // Randomized instruction mix
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      r = 16'($urandom);
      if (sel < 4)      opc = 3'b101;
      else if (sel < 7) opc = 3'b110;
      else              opc = 3'($urandom);
      r[15:13] = opc;
      run_instr(r, 3'($urandom), (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
